morph_window_buffer: RTL and testbench

Streaming window generator sitting directly upstream of the dilation node in the morphology datapath. Accepts a raster-order binary pixel stream and assembles, per accepted pixel, a Width×Height neighbourhood in the bit layout the dilation node consumes on its D input. Uses Height-1 line buffers and a window shift array, with a one-deep registered valid/ready output stage.

---
 rtl/morph_pkg.sv | 28 ++
 rtl/morph_line_buffer.sv | 53 +++++
 rtl/morph_window_buffer.sv | 175 +++++++++++++++++
 tb/tb_morph_window_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// ============================================================================
// Module      : morph_pkg
// Description : Shared constants and helpers for the morphology window path:
//               window bit indexing, counter sizing, default frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package morph_pkg;

    // Default frame geometry for the morphology datapath
    localparam int C_DEF_IMAGE_WIDTH  = 640;
    localparam int C_DEF_IMAGE_HEIGHT = 480;

    // Bit position of window element (line l, column c); matches the
    // dilation node's D input layout
    function automatic int win_idx(input int l, input int c, input int width);
        return l * width + c;
    endfunction

    // Counter width for a 0..bound-1 counter, never narrower than one bit
    function automatic int cnt_w(input int bound);
        return (bound <= 1) ? 1 : $clog2(bound);
    endfunction

endpackage

`default_nettype wire

// File: rtl/morph_line_buffer.sv
// ============================================================================
// Module      : morph_line_buffer
// Description : 1-bit delay line of exactly ImageWidth enabled steps. The
//               output is the input seen ImageWidth enables earlier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morph_line_buffer
    import morph_pkg::*;
#(
    parameter int ImageWidth = C_DEF_IMAGE_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_din,
    output logic o_dout
);

    generate
        if (ImageWidth == 1) begin : g_single
            logic r_q;

            // Single-stage delay when the line is one pixel wide
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= 1'b0;
                end else if (i_en) begin
                    r_q <= i_din;
                end
            end

            assign o_dout = r_q;
        end else begin : g_shift
            logic [ImageWidth-1:0] r_sr;

            // Shift one position per accepted pixel; oldest bit at the top
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sr <= '0;
                end else if (i_en) begin
                    r_sr <= {r_sr[ImageWidth-2:0], i_din};
                end
            end

            assign o_dout = r_sr[ImageWidth-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/morph_window_buffer.sv
// ============================================================================
// Module      : morph_window_buffer
// Description : Streaming Width x Height binary window generator feeding the
//               dilation node. Height-1 line buffers plus a window shift
//               array, with a one-deep registered valid/ready output stage.
//               Optional macro MORPH_WINDOW_BORDER_EN: emit a window for every
//               accepted pixel, zero-padding bits outside the frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morph_window_buffer
    import morph_pkg::*;
#(
    parameter int Width       = 3,
    parameter int Height      = 3,
    parameter int ImageWidth  = C_DEF_IMAGE_WIDTH,
    parameter int ImageHeight = C_DEF_IMAGE_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_pixel,
    input  logic                      in_sof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [Width*Height-1:0]   out_window,
    output logic                      out_eof
);

    localparam int C_N     = Width * Height;
    localparam int C_COL_W = cnt_w(ImageWidth);
    localparam int C_ROW_W = cnt_w(ImageHeight);

    localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(ImageWidth - 1);
    localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(ImageHeight - 1);

    logic [C_COL_W-1:0] r_col;
    logic [C_COL_W-1:0] w_pos_col;
    logic [C_COL_W-1:0] w_col_next;
    logic [C_ROW_W-1:0] r_row;
    logic [C_ROW_W-1:0] w_pos_row;
    logic [C_ROW_W-1:0] w_row_next;

    logic [C_N-1:0]     r_win;
    logic [C_N-1:0]     w_win_next;
    logic [C_N-1:0]     w_out_window;
    logic [Height-1:0]  w_new_col;

    logic               r_out_valid;
    logic [C_N-1:0]     r_out_window;
    logic               r_out_eof;

    logic               w_accept;
    logic               w_due;
    logic               w_eof;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    assign out_valid  = r_out_valid;
    assign out_window = r_out_window;
    assign out_eof    = r_out_eof;

    // Position of the pixel being accepted; start-of-frame restarts at (0,0)
    assign w_pos_col = in_sof ? '0 : r_col;
    assign w_pos_row = in_sof ? '0 : r_row;

    assign w_eof = (w_pos_row == C_ROW_LAST) && (w_pos_col == C_COL_LAST);

    // Raster advance from the accepted pixel's position, wrapping at frame end
    always_comb begin
        w_col_next = w_pos_col + C_COL_W'(1);
        w_row_next = w_pos_row;
        if (w_pos_col == C_COL_LAST) begin
            w_col_next = '0;
            w_row_next = (w_pos_row == C_ROW_LAST) ? '0 : (w_pos_row + C_ROW_W'(1));
        end
    end

    // Newest column: line buffer taps for the older lines, live pixel at the bottom
    assign w_new_col[Height-1] = in_pixel;

    generate
        if (Height > 1) begin : g_lines
            for (genvar k = 0; k < Height - 1; k++) begin : g_lb
                morph_line_buffer #(
                    .ImageWidth (ImageWidth)
                ) u_line (
                    .clk    (clk),
                    .rst    (rst),
                    .i_en   (w_accept),
                    .i_din  (w_new_col[k+1]),
                    .o_dout (w_new_col[k])
                );
            end
        end
    endgenerate

    // Shift the window one column left and insert the newest column on the right
    always_comb begin
        w_win_next = r_win;
        for (int l = 0; l < Height; l++) begin
            for (int c = 0; c < Width; c++) begin
                if (c == Width - 1) begin
                    w_win_next[win_idx(l, c, Width)] = w_new_col[l];
                end else begin
                    w_win_next[win_idx(l, c, Width)] = r_win[win_idx(l, c + 1, Width)];
                end
            end
        end
    end

`ifdef MORPH_WINDOW_BORDER_EN
    // Every pixel yields a window; bits reaching above/left of the frame read 0
    always_comb begin
        w_out_window = w_win_next;
        for (int l = 0; l < Height; l++) begin
            for (int c = 0; c < Width; c++) begin
                if ((int'(w_pos_row) < Height - 1 - l) || (int'(w_pos_col) < Width - 1 - c)) begin
                    w_out_window[win_idx(l, c, Width)] = 1'b0;
                end
            end
        end
    end

    assign w_due = 1'b1;
`else
    localparam logic [C_COL_W-1:0] C_COL_FULL = C_COL_W'(Width - 1);
    localparam logic [C_ROW_W-1:0] C_ROW_FULL = C_ROW_W'(Height - 1);

    // Only windows lying wholly inside the frame are emitted
    assign w_out_window = w_win_next;
    assign w_due        = (w_pos_row >= C_ROW_FULL) && (w_pos_col >= C_COL_FULL);
`endif

    // Position counters advance once per accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end
    end

    // Window shift array holds the raw (unmasked) neighbourhood
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_accept) begin
            r_win <= w_win_next;
        end
    end

    // One-deep output register: load on a due accept, drop once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_window <= '0;
            r_out_eof    <= 1'b0;
        end else if (w_accept && w_due) begin
            r_out_valid  <= 1'b1;
            r_out_window <= w_out_window;
            r_out_eof    <= w_eof;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_morph_window_buffer.sv
// ============================================================================
// Module      : tb_morph_window_buffer
// Description : Self-checking bench for morph_window_buffer (3x3 window on a
//               5x4 frame). An image-based model predicts each window from
//               the pixels accepted so far; directed phases pin the model.
//               Honours MORPH_WINDOW_BORDER_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morph_window_buffer;

    localparam int W  = 3;
    localparam int H  = 3;
    localparam int IW = 5;
    localparam int IH = 4;
    localparam int N  = W * H;

`ifdef MORPH_WINDOW_BORDER_EN
    localparam int C_FRAME_WIN = IW * IH;
    localparam int C_SOF_LAT   = 1;
`else
    localparam int C_FRAME_WIN = (IW - W + 1) * (IH - H + 1);
    localparam int C_SOF_LAT   = (H - 1) * IW + W;
`endif

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_pixel  = 1'b0;
    logic         in_sof    = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_eof;
    logic [N-1:0] out_window;

    always #5 clk = ~clk;

    morph_window_buffer #(
        .Width       (W),
        .Height      (H),
        .ImageWidth  (IW),
        .ImageHeight (IH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_eof    (out_eof)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           img [IH][IW];
    int           m_row = 0;
    int           m_col = 0;
    logic [N-1:0] qw[$];
    bit           qe[$];
    int           qr[$];
    int           qc[$];
    logic [N-1:0] exp_win [IH][IW];

    bit s_acc  = 0;
    bit s_cons = 0;
    bit s_pix  = 0;
    bit s_sof  = 0;

    // Consumed windows logged by position
    logic [N-1:0] got_win [IH][IW];
    bit           got_eof [IH][IW];
    int           n_win = 0;
    int           n_eof = 0;

    // Model update at each clock edge using handshakes sampled on the prior negedge
    always @(posedge clk or posedge rst) begin : model
        logic [N-1:0] ew;
        bit           due;
        int           r;
        int           cc;
        if (rst) begin
            qw.delete(); qe.delete(); qr.delete(); qc.delete();
            m_row = 0;
            m_col = 0;
        end else begin
            if (s_cons && qw.size() > 0) begin
                void'(qw.pop_front()); void'(qe.pop_front());
                void'(qr.pop_front()); void'(qc.pop_front());
            end
            if (s_acc) begin
                if (s_sof) begin
                    m_row = 0;
                    m_col = 0;
                end
                img[m_row][m_col] = s_pix;
                ew = '0;
                for (int l = 0; l < H; l++) begin
                    for (int c = 0; c < W; c++) begin
                        r  = m_row - (H - 1 - l);
                        cc = m_col - (W - 1 - c);
                        if (r >= 0 && cc >= 0) ew[l*W + c] = img[r][cc];
                    end
                end
`ifdef MORPH_WINDOW_BORDER_EN
                due = 1'b1;
`else
                due = (m_row >= H - 1) && (m_col >= W - 1);
`endif
                if (due) begin
                    qw.push_back(ew);
                    qe.push_back((m_row == IH - 1) && (m_col == IW - 1));
                    qr.push_back(m_row);
                    qc.push_back(m_col);
                    exp_win[m_row][m_col] = ew;
                end
                m_col++;
                if (m_col == IW) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == IH) m_row = 0;
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        s_acc  = 0;
        s_cons = 0;
        if (!rst) begin
            s_acc  = in_valid && in_ready;
            s_cons = out_valid && out_ready;
            s_pix  = in_pixel;
            s_sof  = in_sof;
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (out_valid) begin
                if (qw.size() == 0) begin
                    chk("spurious_window", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("window", {{(32-N){1'b0}}, out_window}, {{(32-N){1'b0}}, qw[0]});
                    chk("eof", {31'd0, out_eof}, {31'd0, qe[0]});
                    if (out_ready) begin
                        got_win[qr[0]][qc[0]] = out_window;
                        got_eof[qr[0]][qc[0]] = out_eof;
                        n_win++;
                        if (out_eof) n_eof++;
                    end
                end
            end else begin
                chk("missing_window", qw.size(), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rnd_rdy = 0;

    task automatic send(input logic pix, input logic sof);
        int t;
        bit done;
        t    = 0;
        done = 0;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        in_valid = 1'b1;
        in_pixel = pix;
        in_sof   = sof;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else if (t >= 200) begin
                chk("accept_timeout", {31'd0, in_ready}, 32'd1);
                done = 1;
            end else begin
                t++;
                @(posedge clk); #1;
                if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        int base_e;
        int n;
        bit seen;
        bit held;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("reset_out_window", {{(32-N){1'b0}}, out_window}, 32'd0);
        chk("reset_out_eof",    {31'd0, out_eof}, 32'd0);
        chk("reset_in_ready",   {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-ones frame at full throughput
        out_ready = 1'b1;
        base   = n_win;
        base_e = n_eof;
        for (int i = 0; i < IW * IH; i++) send(1'b1, i == 0);
        drain();
        chk("ones_count",     n_win - base, C_FRAME_WIN);
        chk("ones_eof_count", n_eof - base_e, 32'd1);
        chk("ones_eof_last",  {31'd0, got_eof[IH-1][IW-1]}, 32'd1);
        chk("ones_win_2_2",   {23'd0, got_win[2][2]}, 32'h1FF);
        chk("ones_win_3_4",   {23'd0, got_win[3][4]}, 32'h1FF);
`ifdef MORPH_WINDOW_BORDER_EN
        chk("border_win_0_0",   {23'd0, got_win[0][0]}, 32'h100);
        chk("border_win_1_1",   {23'd0, got_win[1][1]}, 32'h1B0);
        chk("border_model_1_1", {23'd0, exp_win[1][1]}, 32'h1B0);
`endif

        // Single set pixel at (1,1)
        for (int i = 0; i < IW * IH; i++) send(i == IW + 1, i == 0);
        drain();
        chk("dot_win_2_2",   {23'd0, got_win[2][2]}, 32'h010);
        chk("dot_win_2_3",   {23'd0, got_win[2][3]}, 32'h008);
        chk("dot_win_3_3",   {23'd0, got_win[3][3]}, 32'h001);
        chk("dot_model_2_2", {23'd0, exp_win[2][2]}, 32'h010);
        chk("dot_model_3_3", {23'd0, exp_win[3][3]}, 32'h001);

        // Back-pressure on the first window, then release
        base = n_win;
        held = 0;
        for (int k = 0; k < IW * IH; k++) begin
            send(1'($urandom_range(0, 1)), k == 0);
            if (out_valid && !held) begin
                held      = 1;
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_pixel  = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    chk("hold_in_ready",  {31'd0, in_ready}, 32'd0);
                    chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
                    if (qw.size() > 0)
                        chk("hold_window", {{(32-N){1'b0}}, out_window}, {{(32-N){1'b0}}, qw[0]});
                end
                @(posedge clk); #1;
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
        end
        drain();
        chk("bp_count", n_win - base, C_FRAME_WIN);

        // Mid-frame restart: counters reach (2,3), then in_sof
        for (int i = 0; i < 2 * IW + 3; i++) send(1'($urandom_range(0, 1)), i == 0);
        n    = 0;
        seen = 0;
        while (n < 30 && !seen) begin
            send(1'($urandom_range(0, 1)), n == 0);
            n++;
            seen = out_valid;
        end
        chk("sof_latency", n, C_SOF_LAT);
        drain();

        // Randomized traffic with random gaps, back-pressure and restarts
        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 1) != 0);
            end
            send(1'($urandom_range(0, 1)), (i % (IW * IH) == 0) || ($urandom_range(0, 40) == 0));
        end
        rnd_rdy = 0;
        drain();

        // Asynchronous reset while a window is held
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            send(1'b1, n == 0);
            n++;
        end
        chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        in_pixel = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_out_window", {{(32-N){1'b0}}, out_window}, 32'd0);
        chk("rst_out_eof",    {31'd0, out_eof}, 32'd0);
        chk("rst_in_ready",   {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        base   = n_win;
        base_e = n_eof;
        for (int i = 0; i < IW * IH; i++) send(1'b1, 1'b0);
        drain();
        chk("post_rst_count",    n_win - base, C_FRAME_WIN);
        chk("post_rst_eof_cnt",  n_eof - base_e, 32'd1);
        chk("post_rst_eof_last", {31'd0, got_eof[IH-1][IW-1]}, 32'd1);
        chk("post_rst_win_3_4",  {23'd0, got_win[3][4]}, 32'h1FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
